// File: rtl/sort_fp_pkg.sv
// Shared types and constants for the streaming FP32 frame sorter.
package sort_fp_pkg;

    localparam int FP_W = 32;

    // Largest positive pattern: always orders after any real word.
    localparam logic [FP_W-1:0] FP_PAD = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fp_minmax.sv
// Bitwise FP32 compare-exchange: sign first, then magnitude.
module fp_minmax
    import sort_fp_pkg::*;
#(
    parameter int W = FP_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] min,
    output logic [W-1:0] max
);

    logic w_a_lt_b;

    // Negative magnitudes order in reverse.
    always_comb begin
        w_a_lt_b = 1'b0;
        if (a[W-1] != b[W-1]) begin
            w_a_lt_b = a[W-1];
        end else if (!a[W-1]) begin
            w_a_lt_b = (a[W-2:0] < b[W-2:0]);
        end else begin
            w_a_lt_b = (a[W-2:0] > b[W-2:0]);
        end
    end

    assign min = w_a_lt_b ? a : b;
    assign max = w_a_lt_b ? b : a;

endmodule

// File: rtl/sort_fp.sv
// Streaming FP32 frame sorter: load a frame, run N odd-even
// transposition passes in place, then drain ascending.
module sort_fp
    import sort_fp_pkg::*;
#(
    parameter int N = 8,
    parameter int W = FP_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready
);

    localparam int CW = $clog2(N + 1);
    localparam int PW = $clog2(N);
    localparam int HP = N / 2;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_buf [N];
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_rd;
    logic [PW-1:0]  r_pass;

    logic [W-1:0]   w_a   [HP];
    logic [W-1:0]   w_b   [HP];
    logic [W-1:0]   w_min [HP];
    logic [W-1:0]   w_max [HP];
    logic [W-1:0]   w_srt [N];
    logic [W-1:0]   w_rd_word;

    logic           w_odd;
    logic           w_in_fire;
    logic           w_close;
    logic           w_sort_done;
    logic           w_out_fire;

    assign w_odd       = r_pass[0];
    assign w_in_fire   = in_valid & in_ready;
    assign w_close     = w_in_fire & (in_last | (r_cnt == CW'(N - 1)));
    assign w_sort_done = (r_pass == PW'(N - 1));
    assign w_out_fire  = out_valid & out_ready;

    // Even-pass wiring; odd passes shift each comparator up one slot.
    for (genvar j = 0; j < HP; j++) begin : g_cmp
        assign w_a[j] = w_odd ? r_buf[2*j+1] : r_buf[2*j];
        if (j < HP - 1) begin : g_mid
            assign w_b[j] = w_odd ? r_buf[2*j+2] : r_buf[2*j+1];
        end else begin : g_top
            assign w_b[j] = r_buf[2*j+1];
        end

        fp_minmax #(
            .W (W)
        ) u_cmp (
            .a   (w_a[j]),
            .b   (w_b[j]),
            .min (w_min[j]),
            .max (w_max[j])
        );
    end

    for (genvar i = 0; i < N; i++) begin : g_pos
        logic [W-1:0] w_ev;
        logic [W-1:0] w_od;
        if (i % 2 == 0) begin : g_even
            assign w_ev = w_min[i/2];
            if (i == 0) begin : g_edge
                assign w_od = r_buf[i];
            end else begin : g_in
                assign w_od = w_max[(i-2)/2];
            end
        end else begin : g_oddi
            assign w_ev = w_max[i/2];
            if (i == N - 1) begin : g_edge
                assign w_od = r_buf[i];
            end else begin : g_in
                assign w_od = w_min[(i-1)/2];
            end
        end
        assign w_srt[i] = w_odd ? w_od : w_ev;
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < N; i++) begin
            if (r_rd == CW'(i)) begin
                w_rd_word = r_buf[i];
            end
        end
    end

    assign in_ready  = (r_state == LOAD) & ~rst;
    assign out_valid = (r_state == DRAIN);
    assign out_data  = out_valid ? w_rd_word : '0;
    assign out_last  = out_valid & (r_rd == r_cnt - CW'(1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            LOAD: begin
                if (w_close) begin
                    w_state_nxt = SORT;
                end
            end
            SORT: begin
                if (w_sort_done) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_out_fire && out_last) begin
                    w_state_nxt = LOAD;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_rd    <= '0;
            r_pass  <= '0;
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        // Closing word also pads the unused tail.
                        for (int i = 0; i < N; i++) begin
                            if (r_cnt == CW'(i)) begin
                                r_buf[i] <= in_data;
                            end else if (w_close && (CW'(i) > r_cnt)) begin
                                r_buf[i] <= FP_PAD;
                            end
                        end
                        r_cnt <= r_cnt + CW'(1);
                        if (w_close) begin
                            r_pass <= '0;
                        end
                    end
                end
                SORT: begin
                    for (int i = 0; i < N; i++) begin
                        r_buf[i] <= w_srt[i];
                    end
                    if (w_sort_done) begin
                        r_pass <= '0;
                        r_rd   <= '0;
                    end else begin
                        r_pass <= r_pass + PW'(1);
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        if (out_last) begin
                            r_rd  <= '0;
                            r_cnt <= '0;
                        end else begin
                            r_rd <= r_rd + CW'(1);
                        end
                    end
                end
                default: begin
                    r_rd <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_fp.sv
// Randomized bench for sort_fp against a queue-based sorting model.
module tb_sort_fp;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    sort_fp #(
        .N (N),
        .W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    logic [31:0] frm[$];
    logic [31:0] mdl[$];
    logic [31:0] lit[$];
    int          rdy_mode = 0;
    int          pat_i = 0;
    bit          pat[6] = '{1, 0, 0, 1, 0, 1};
    logic [31:0] specials[8] = '{32'h0000_0000, 32'h8000_0000,
                                 32'h7F80_0000, 32'hFF80_0000,
                                 32'h7FC0_0000, 32'h3F80_0000,
                                 32'hBF80_0000, 32'h0000_0001};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monotone key: unsigned compare of keys gives the FP bit ordering.
    function automatic logic [31:0] okey(input logic [31:0] x);
        return x[31] ? ~x : {1'b1, x[30:0]};
    endfunction

    task automatic model_sort();
        logic [31:0] t;
        mdl = frm;
        for (int i = 1; i < mdl.size(); i++) begin
            for (int j = i; j > 0; j--) begin
                if (okey(mdl[j-1]) > okey(mdl[j])) begin
                    t = mdl[j-1];
                    mdl[j-1] = mdl[j];
                    mdl[j] = t;
                end
            end
        end
    endtask

    task automatic pin_model(input string nm);
        model_sort();
        chk({nm, "_len"}, mdl.size(), lit.size());
        for (int i = 0; i < lit.size(); i++) begin
            chk(nm, mdl[i], lit[i]);
        end
    endtask

    task automatic send_frame(input bit use_last);
        int w;
        model_sort();
        for (int i = 0; i < mdl.size(); i++) begin
            exp_d.push_back(mdl[i]);
            exp_l.push_back(i == mdl.size() - 1);
        end
        for (int i = 0; i < frm.size(); i++) begin
            in_data  = frm[i];
            in_valid = 1'b1;
            in_last  = use_last && (i == frm.size() - 1);
            w = 0;
            while (!in_ready && w < 200) begin
                @(posedge clk);
                #1;
                w++;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", in_ready, 1);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(exp_d.size() == 0 && in_ready) && w < 2000);
        chk("drain_done", (exp_d.size() == 0) && in_ready, 1);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = pat[pat_i];
                pat_i = (pat_i + 1) % 6;
            end
        endcase
    end

    logic [31:0] pv_d;
    logic        pv_l;
    bit          pv_stall = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_d.delete();
            exp_l.delete();
            pv_stall = 0;
        end else begin
            if (pv_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pv_d);
                chk("hold_last", out_last, pv_l);
            end
            if (out_valid) begin
                chk("no_overlap", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_word: got %h, expected none",
                             out_data);
                end else begin
                    chk("out_data", out_data, exp_d.pop_front());
                    chk("out_last", out_last, exp_l.pop_front());
                end
            end
            pv_stall = out_valid && !out_ready;
            pv_d     = out_data;
            pv_l     = out_last;
        end
    end

    initial begin
        int len;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Full frame closed by count, with latency and ignored input.
        frm = '{32'h4040_0000, 32'hBF80_0000, 32'h3F00_0000, 32'hC000_0000,
                32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000};
        lit = '{32'hFF80_0000, 32'hC000_0000, 32'hBF80_0000, 32'h8000_0000,
                32'h0000_0000, 32'h3F00_0000, 32'h4040_0000, 32'h7F80_0000};
        pin_model("pin_full");
        rdy_mode = 0;
        send_frame(1'b0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_last  = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("lat_in_ready", in_ready, 0);
            chk("lat_out_valid", out_valid, 0);
        end
        @(negedge clk);
        chk("lat_out_valid_rise", out_valid, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle();

        // Short frame: padding must not appear.
        frm = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
        lit = '{32'hBF80_0000, 32'h0000_0000, 32'h3F80_0000};
        pin_model("pin_short");
        send_frame(1'b1);
        wait_idle();

        // One-word frame.
        frm = '{32'hC2C8_0000};
        send_frame(1'b1);
        wait_idle();

        // Backpressure pattern during drain.
        frm.delete();
        for (int i = 0; i < N; i++) frm.push_back($urandom);
        rdy_mode = 2;
        pat_i = 0;
        send_frame(1'b1);
        wait_idle();
        rdy_mode = 0;

        // All-negative reverse input, in_last on the N-th word.
        frm = '{32'hBF80_0000, 32'hC000_0000, 32'hC040_0000, 32'hC080_0000,
                32'hBF80_0000, 32'hC000_0000, 32'hC040_0000, 32'hC080_0000};
        lit = '{32'hC080_0000, 32'hC080_0000, 32'hC040_0000, 32'hC040_0000,
                32'hC000_0000, 32'hC000_0000, 32'hBF80_0000, 32'hBF80_0000};
        pin_model("pin_neg");
        send_frame(1'b1);
        wait_idle();

        // Reset in SORT at pass 3 aborts the frame.
        frm = '{32'h4120_0000, 32'h3F80_0000, 32'hC120_0000, 32'h0000_0000,
                32'h8000_0000};
        send_frame(1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        frm = '{32'h4000_0000, 32'h3F80_0000};
        lit = '{32'h3F80_0000, 32'h4000_0000};
        pin_model("pin_two");
        send_frame(1'b1);
        wait_idle();

        // Randomized frames with random backpressure.
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, N);
            frm.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) == 0)
                    frm.push_back(specials[$urandom_range(0, 7)]);
                else
                    frm.push_back($urandom);
            end
            send_frame((len < N) ? 1'b1 : 1'($urandom_range(0, 1)));
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
